// File: rtl/ndata_upsizer_if.sv
// Lane-oriented stream bus: WIDTH elements of data_t per beat, per-element keep,
// packet last and a valid/ready handshake.
interface ndata_i #(
  parameter type         data_t = logic [7:0],
  parameter int unsigned WIDTH  = 8
);
  data_t [WIDTH-1:0] data;
  logic  [WIDTH-1:0] keep;
  logic              last;
  logic              valid;
  logic              ready;

  modport m (output data, keep, last, valid, input ready);
  modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/ndata_upsizer.sv
// Packs RATIO narrow ndata beats into one wide beat. A separate assembly buffer and
// output register let non-completing beats flow in while the output is stalled.
module ndata_upsizer #(
  parameter type                data_t    = logic [7:0],
  parameter int unsigned        IN_WIDTH  = 8,
  parameter int unsigned        RATIO     = 2,
  localparam int unsigned       OUT_WIDTH = IN_WIDTH * RATIO
) (
  input logic clk,
  input logic rst,
  ndata_i.s   in,
  ndata_i.m   out
);

  localparam int unsigned     IdxW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(RATIO - 1);

  data_t [OUT_WIDTH-1:0] asm_data_q, asm_data_d;
  logic  [OUT_WIDTH-1:0] asm_keep_q, asm_keep_d;
  logic  [IdxW-1:0]      idx_q, idx_d;
  data_t [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic  [OUT_WIDTH-1:0] out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;

  data_t [OUT_WIDTH-1:0] merged_data;
  logic  [OUT_WIDTH-1:0] merged_keep;
  logic                  completes;
  logic                  accept;

  assign completes = (idx_q == LastIdx) || in.last;
  // A completing beat needs the output register; all other beats only touch the buffer.
  assign in.ready  = !out_valid_q || out.ready || !completes;
  assign accept    = in.valid && in.ready;

  assign out.data  = out_data_q;
  assign out.keep  = out_keep_q;
  assign out.last  = out_last_q;
  assign out.valid = out_valid_q;

  always_comb begin
    merged_data = '0;
    merged_keep = '0;
    for (int l = 0; l < int'(RATIO); l++) begin
      if (l < int'(idx_q)) begin
        merged_data[l*IN_WIDTH +: IN_WIDTH] = asm_data_q[l*IN_WIDTH +: IN_WIDTH];
        merged_keep[l*IN_WIDTH +: IN_WIDTH] = asm_keep_q[l*IN_WIDTH +: IN_WIDTH];
      end else if (l == int'(idx_q)) begin
        merged_data[l*IN_WIDTH +: IN_WIDTH] = in.data;
        merged_keep[l*IN_WIDTH +: IN_WIDTH] = in.keep;
      end
    end
  end

  always_comb begin
    asm_data_d  = asm_data_q;
    asm_keep_d  = asm_keep_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out.ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (completes) begin
        out_data_d  = merged_data;
        out_keep_d  = merged_keep;
        out_last_d  = in.last;
        out_valid_d = 1'b1;
        idx_d       = '0;
        asm_keep_d  = '0;
      end else begin
        // Lanes above idx are never read before being rewritten, so zeroing them is harmless.
        asm_data_d = merged_data;
        asm_keep_d = merged_keep;
        idx_d      = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_data_q  <= '0;
      asm_keep_q  <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      asm_data_q  <= asm_data_d;
      asm_keep_q  <= asm_keep_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_ndata_upsizer.sv
// Self-checking bench for ndata_upsizer: directed table and corner sequences on a 4x4
// instance, a latency check on an 8x2 instance, and random streams for RATIO 1, 3 and 8.
module tb_ndata_upsizer;

  typedef logic [7:0] byte_t;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } exp_t;

  typedef struct {
    logic [31:0]  d;
    logic [3:0]   k;
    logic         l;
    logic         emit;
    logic [127:0] ed;
    logic [15:0]  ek;
    logic         el;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   tests;
  int   fails;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 8 lanes x 2 beats instance
  ndata_i #(.data_t(byte_t), .WIDTH(8))  a_in ();
  ndata_i #(.data_t(byte_t), .WIDTH(16)) a_out ();
  ndata_upsizer #(.data_t(byte_t), .IN_WIDTH(8), .RATIO(2)) u_a (
    .clk (clk),
    .rst (rst),
    .in  (a_in),
    .out (a_out)
  );

  // 4 lanes x 4 beats instance
  ndata_i #(.data_t(byte_t), .WIDTH(4))  b_in ();
  ndata_i #(.data_t(byte_t), .WIDTH(16)) b_out ();
  ndata_upsizer #(.data_t(byte_t), .IN_WIDTH(4), .RATIO(4)) u_b (
    .clk (clk),
    .rst (rst),
    .in  (b_in),
    .out (b_out)
  );

  exp_t         b_q[$];
  logic         b_hold_seen;
  logic [144:0] b_hold_val;

  initial begin : b_monitor
    logic [144:0] cur;
    exp_t         e;
    b_hold_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !b_out.valid) begin
        if (!rst && b_hold_seen) chk("b_valid_drop", b_out.valid, 1);
        b_hold_seen = 1'b0;
      end else begin
        cur = {b_out.data, b_out.keep, b_out.last};
        if (b_hold_seen) chk("b_hold", cur, b_hold_val);
        if (b_out.ready) begin
          chk("b_have_exp", b_q.size() != 0, 1);
          if (b_q.size() != 0) begin
            e = b_q.pop_front();
            chk("b_beat", cur, e);
          end
          b_hold_seen = 1'b0;
        end else begin
          b_hold_seen = 1'b1;
          b_hold_val  = cur;
        end
      end
    end
  end

  task automatic b_send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n           = 0;
    b_in.valid  = 1'b1;
    b_in.data   = d;
    b_in.keep   = k;
    b_in.last   = l;
    @(negedge clk);
    while (!b_in.ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("b_in_ready_timeout", b_in.ready, 1);
    @(posedge clk);
    #1;
    b_in.valid = 1'b0;
  endtask

  // Random streams
  for (genvar g = 0; g < 3; g++) begin : gen_rnd
    localparam int unsigned R = (g == 0) ? 1 : (g == 1) ? 3 : 8;

    ndata_i #(.data_t(byte_t), .WIDTH(2))     r_in ();
    ndata_i #(.data_t(byte_t), .WIDTH(2 * R)) r_out ();
    ndata_upsizer #(.data_t(byte_t), .IN_WIDTH(2), .RATIO(R)) u_dut (
      .clk (clk),
      .rst (rst),
      .in  (r_in),
      .out (r_out)
    );

    exp_t q[$];
    logic done = 1'b0;

    initial begin : driver
      logic [127:0] md;
      logic [15:0]  mk;
      logic [15:0]  d;
      logic [1:0]   k;
      int           mi, len, n;
      r_in.valid = 1'b0;
      r_in.data  = '0;
      r_in.keep  = '0;
      r_in.last  = 1'b0;
      md = '0;
      mk = '0;
      mi = 0;
      wait (start);
      @(posedge clk);
      #1;
      for (int p = 0; p < 1000; p++) begin
        len = $urandom_range(1, 2 * R);
        for (int b = 0; b < len; b++) begin
          while ($urandom_range(0, 1) == 0) begin
            @(posedge clk);
            #1;
          end
          d          = 16'($urandom);
          k          = 2'($urandom);
          r_in.valid = 1'b1;
          r_in.data  = d;
          r_in.keep  = k;
          r_in.last  = (b == len - 1);
          n = 0;
          @(negedge clk);
          while (!r_in.ready && n < 1000) begin
            n++;
            @(negedge clk);
          end
          if (n >= 1000) chk("rnd_in_ready_timeout", r_in.ready, 1);
          @(posedge clk);
          #1;
          r_in.valid = 1'b0;
          md[mi*16 +: 16] = d;
          mk[mi*2 +: 2]   = k;
          if (mi == int'(R) - 1 || b == len - 1) begin
            q.push_back('{d: md, k: mk, l: (b == len - 1)});
            md = '0;
            mk = '0;
            mi = 0;
          end else begin
            mi++;
          end
        end
      end
      n = 0;
      while (q.size() != 0 && n < 2000) begin
        @(posedge clk);
        n++;
      end
      chk("rnd_drain", q.size(), 0);
      done = 1'b1;
    end

    initial begin : ready_gen
      r_out.ready = 1'b0;
      wait (start);
      forever begin
        @(posedge clk);
        #1;
        r_out.ready = 1'($urandom_range(0, 1));
      end
    end

    initial begin : monitor
      logic         hold_seen;
      logic [144:0] hold_val;
      logic [144:0] cur;
      exp_t         e;
      hold_seen = 1'b0;
      forever begin
        @(negedge clk);
        if (rst || !r_out.valid) begin
          if (!rst && hold_seen) chk("rnd_valid_drop", r_out.valid, 1);
          hold_seen = 1'b0;
        end else begin
          cur = {128'(r_out.data), 16'(r_out.keep), r_out.last};
          if (hold_seen) chk("rnd_hold", cur, hold_val);
          if (r_out.ready) begin
            chk("rnd_have_exp", q.size() != 0, 1);
            if (q.size() != 0) begin
              e = q.pop_front();
              chk("rnd_beat", cur, e);
            end
            hold_seen = 1'b0;
          end else begin
            hold_seen = 1'b1;
            hold_val  = cur;
          end
        end
      end
    end
  end

  vec_t tbl[10];

  initial begin : main
    int n;
    tests = 0;
    fails = 0;
    start = 1'b0;
    rst   = 1'b1;
    a_in.valid = 1'b0; a_in.data = '0; a_in.keep = '0; a_in.last = 1'b0; a_out.ready = 1'b1;
    b_in.valid = 1'b0; b_in.data = '0; b_in.keep = '0; b_in.last = 1'b0; b_out.ready = 1'b1;

    tbl[0] = '{32'h13121110, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
    tbl[1] = '{32'h17161514, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
    tbl[2] = '{32'h1B1A1918, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
    tbl[3] = '{32'h1F1E1D1C, 4'hF, 1'b0, 1'b1,
               128'h1F1E1D1C_1B1A1918_17161514_13121110, 16'hFFFF, 1'b0};
    tbl[4] = '{32'h23222120, 4'hF, 1'b1, 1'b1, 128'h23222120, 16'h000F, 1'b1};
    tbl[5] = '{32'hDEADBEEF, 4'h0, 1'b1, 1'b1, 128'hDEADBEEF, 16'h0000, 1'b1};
    tbl[6] = '{32'h33323130, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
    tbl[7] = '{32'h37363534, 4'hF, 1'b1, 1'b1, 128'h37363534_33323130, 16'h00FF, 1'b1};
    tbl[8] = '{32'h43424140, 4'h3, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
    tbl[9] = '{32'h47464544, 4'h8, 1'b1, 1'b1, 128'h47464544_43424140, 16'h0083, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_b_valid", b_out.valid, 0);
    chk("rst_b_last", b_out.last, 0);
    chk("rst_b_keep", b_out.keep, 0);
    chk("rst_b_data", b_out.data, 0);
    chk("rst_b_in_ready", b_in.ready, 1);
    chk("rst_a_valid", a_out.valid, 0);

    // 8x2: A then B(last) -> {B,A} one cycle after B is accepted
    a_in.valid = 1'b1; a_in.data = 64'h07060504_03020100; a_in.keep = 8'hFF; a_in.last = 1'b0;
    @(negedge clk);
    chk("a_in_ready", a_in.ready, 1);
    @(posedge clk);
    #1;
    chk("a_no_out_after_a", a_out.valid, 0);
    a_in.data = 64'h17161514_13121110; a_in.last = 1'b1;
    @(posedge clk);
    #1;
    a_in.valid = 1'b0;
    chk("a_out_valid", a_out.valid, 1);
    chk("a_out_data", a_out.data, 128'h17161514_13121110_07060504_03020100);
    chk("a_out_keep", a_out.keep, 16'hFFFF);
    chk("a_out_last", a_out.last, 1);
    @(posedge clk);
    #1;
    chk("a_drained", a_out.valid, 0);

    // 4x4 table: back-to-back beats, out.ready held high
    for (int i = 0; i < 10; i++) begin
      b_send(tbl[i].d, tbl[i].k, tbl[i].l);
      if (tbl[i].emit) b_q.push_back('{d: tbl[i].ed, k: tbl[i].ek, l: tbl[i].el});
      chk("tbl_valid", b_out.valid, tbl[i].emit);
    end
    @(posedge clk);
    #1;
    chk("tbl_drained", b_out.valid, 0);

    // Output stalled: four beats fill the output, a completing 5th beat must wait
    b_out.ready = 1'b0;
    for (int i = 0; i < 4; i++) b_send(32'h50505050 + 32'(i), 4'hF, 1'b0);
    b_q.push_back('{d: 128'h50505053_50505052_50505051_50505050, k: 16'hFFFF, l: 1'b0});
    b_in.valid = 1'b1; b_in.data = 32'h5A5A5A5A; b_in.keep = 4'hF; b_in.last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", b_in.ready, 0);
    end
    @(posedge clk);
    #1;
    b_out.ready = 1'b1;
    b_q.push_back('{d: 128'h5A5A5A5A, k: 16'h000F, l: 1'b1});
    @(negedge clk);
    chk("drain_in_ready", b_in.ready, 1);
    @(posedge clk);
    #1;
    b_in.valid  = 1'b0;
    b_out.ready = 1'b0;
    chk("no_bubble", b_out.valid, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    b_out.ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_drained", b_out.valid, 0);

    // Reset with a held output beat and a half-built assembly
    b_out.ready = 1'b0;
    for (int i = 0; i < 6; i++) b_send(32'h60606060 + 32'(i), 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", b_out.valid, 0);
    chk("rst_mid_keep", b_out.keep, 0);
    b_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    b_out.ready = 1'b1;
    chk("rst_release_valid", b_out.valid, 0);
    for (int i = 0; i < 4; i++) begin
      b_send(32'h70707070 + 32'(i), 4'hF, 1'b0);
      if (i < 3) chk("post_rst_partial", b_out.valid, 0);
    end
    b_q.push_back('{d: 128'h70707073_70707072_70707071_70707070, k: 16'hFFFF, l: 1'b0});
    @(posedge clk);
    #1;
    chk("b_q_empty", b_q.size(), 0);

    // Random streams on the three remaining instances
    start = 1'b1;
    n = 0;
    while (!(gen_rnd[0].done && gen_rnd[1].done && gen_rnd[2].done) && n < 80000) begin
      @(posedge clk);
      n++;
    end
    chk("rnd_done", {gen_rnd[2].done, gen_rnd[1].done, gen_rnd[0].done}, 3'b111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
